// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: hazard/branch
// controls, the instruction memory port, the IF/ID register outputs and the squash counter.
interface fetch_stage_if #(
  parameter int CNT_W = 16
);
  logic              freeze;
  logic              branch_taken;
  logic [31:0]       branch_addr;
  logic [31:0]       imem_pc;
  logic [31:0]       imem_inst;
  logic [31:0]       id_pc;
  logic [31:0]       id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  squash_count;

  modport master (
    input  freeze,
    input  branch_taken,
    input  branch_addr,
    input  imem_inst,
    output imem_pc,
    output id_pc,
    output id_inst,
    output id_valid,
    output squash_count
  );

  modport slave (
    output freeze,
    output branch_taken,
    output branch_addr,
    output imem_inst,
    input  imem_pc,
    input  id_pc,
    input  id_inst,
    input  id_valid,
    input  squash_count
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory and fills the IF/ID
// register; handles hazard freeze, branch redirect/flush and squash counting.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_REDIRECT = 2'd2
  } action_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  action_e           act_s;
  logic [31:0]       pc_plus4_s;
  logic [31:0]       pc_q,       pc_d;
  logic [31:0]       id_pc_q,    id_pc_d;
  logic [31:0]       id_inst_q,  id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic [CNT_W-1:0]  squash_count_q, squash_count_d;

  // Branch outranks freeze: a redirect with a concurrent stall still flushes.
  always_comb begin
    act_s = ACT_ADVANCE;
    if (bus.branch_taken) begin
      act_s = ACT_REDIRECT;
    end else if (bus.freeze) begin
      act_s = ACT_HOLD;
    end else begin
      act_s = ACT_ADVANCE;
    end
  end

  always_comb begin
    pc_plus4_s     = pc_q + 32'd4;
    pc_d           = pc_q;
    id_pc_d        = id_pc_q;
    id_inst_d      = id_inst_q;
    id_valid_d     = id_valid_q;
    squash_count_d = squash_count_q;
    case (act_s)
      ACT_REDIRECT: begin
        pc_d       = {bus.branch_addr[31:2], 2'b00};
        id_pc_d    = 32'h0000_0000;
        id_inst_d  = 32'h0000_0000;
        id_valid_d = 1'b0;
        if (squash_count_q != CNT_MAX) begin
          squash_count_d = squash_count_q + CNT_ONE;
        end else begin
          squash_count_d = squash_count_q;
        end
      end
      ACT_HOLD: begin
        pc_d = pc_q;
      end
      ACT_ADVANCE: begin
        pc_d       = pc_plus4_s;
        id_pc_d    = pc_plus4_s;
        id_inst_d  = bus.imem_inst;
        id_valid_d = 1'b1;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      id_pc_q        <= 32'h0000_0000;
      id_inst_q      <= 32'h0000_0000;
      id_valid_q     <= 1'b0;
      squash_count_q <= '0;
    end else begin
      pc_q           <= pc_d;
      id_pc_q        <= id_pc_d;
      id_inst_q      <= id_inst_d;
      id_valid_q     <= id_valid_d;
      squash_count_q <= squash_count_d;
    end
  end

  // Memory is combinational, so the address is the PC register itself.
  assign bus.imem_pc      = pc_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_inst      = id_inst_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.squash_count = squash_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, with a
// reference model pushing expectations that a separate monitor pops and checks.
module tb_fetch_stage;

  localparam int CW = 4;

  logic clk;
  logic rst;

  fetch_stage_if #(.CNT_W(CW)) bus_if();

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic          id_valid;
    logic [CW-1:0] sq;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_pass   = 0;

  // model state
  logic [31:0]   m_pc;
  logic [31:0]   m_id_pc;
  logic [31:0]   m_id_inst;
  logic          m_id_valid;
  int            m_sq;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hE3A0_0014;
      32'h0000_0004: mem_word = 32'hE3A0_1A01;
      32'h0000_0008: mem_word = 32'hE3A0_2103;
      default:       mem_word = {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endcase
  endfunction

  assign bus_if.imem_inst = mem_word(bus_if.imem_pc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, predict the next edge.
  task automatic step(input logic r, input logic f, input logic b,
                      input logic [31:0] a, input string nm);
    exp_t e;
    @(negedge clk);
    rst                 = r;
    bus_if.freeze       = f;
    bus_if.branch_taken = b;
    bus_if.branch_addr  = a;
    if (r) begin
      m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_sq = 0;
    end else if (b) begin
      m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
      m_sq = (m_sq + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_sq + 1;
      m_pc = (a / 4) * 4;
    end else if (!f) begin
      m_id_inst  = mem_word(m_pc);
      m_id_pc    = m_pc + 32'd4;
      m_id_valid = 1'b1;
      m_pc       = m_pc + 32'd4;
    end
    e.pc = m_pc; e.id_pc = m_id_pc; e.id_inst = m_id_inst;
    e.id_valid = m_id_valid; e.sq = CW'(m_sq); e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check(e_mon.name, "pc",       bus_if.imem_pc,              e_mon.pc);
      check(e_mon.name, "id_pc",    bus_if.id_pc,                e_mon.id_pc);
      check(e_mon.name, "id_inst",  bus_if.id_inst,              e_mon.id_inst);
      check(e_mon.name, "id_valid", {31'd0, bus_if.id_valid},    {31'd0, e_mon.id_valid});
      check(e_mon.name, "squash",   {28'd0, bus_if.squash_count}, {28'd0, e_mon.sq});
    end
  end

  initial begin
    logic [31:0] ra;
    rst                 = 1'b1;
    bus_if.freeze       = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.branch_addr  = 32'h0;
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_sq = 0;

    step(1'b1, 1'b0, 1'b0, 32'h0, "reset");
    step(1'b1, 1'b0, 1'b0, 32'h0, "reset");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, "run");
    step(1'b0, 1'b0, 1'b0, 32'h0, "run");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, "freeze");
    step(1'b0, 1'b0, 1'b0, 32'h0, "release");
    for (int i = 0; i < 64 && m_pc != 32'h94; i++) step(1'b0, 1'b0, 1'b0, 32'h0, "run");
    step(1'b0, 1'b0, 1'b1, 32'h0000_0074, "branch");
    step(1'b0, 1'b0, 1'b0, 32'h0, "after_branch");
    step(1'b0, 1'b1, 1'b1, 32'h0000_0076, "branch_freeze");
    step(1'b0, 1'b0, 1'b0, 32'h0, "after_bf");
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "branch_top");
    step(1'b0, 1'b0, 1'b0, 32'h0, "wrap");
    step(1'b0, 1'b0, 1'b0, 32'h0, "after_wrap");
    step(1'b0, 1'b1, 1'b0, 32'h0, "pre_rst_freeze");
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040, "rst_in_freeze");
    step(1'b0, 1'b1, 1'b0, 32'h0, "bubble_freeze");
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      step(1'b0, 1'(i % 2), 1'b1, ra, "saturate");
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, "post_sat");
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ra, "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
